beam_threshold_servo: RTL and testbench

Closed-loop threshold controller for the beamform trigger. Counts per-beam trigger assertions over a programmable window, steps each beam's threshold up or down toward a target count, then sequences the new thresholds into the beamform trigger's threshold load port. It runs entirely in the `aclk` domain, alongside the trigger datapath.

---
 rtl/beam_threshold_servo.sv | 167 ++++++++++++++++
 tb/tb_beam_threshold_servo.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/beam_threshold_servo.sv
// rtl/beam_threshold_servo.sv - per-beam trigger-rate threshold servo (LOAD/UPDATE/COUNT/ADJUST loop)
// Optional SERVO_HYST_EN adds the tol_i hysteresis band around the target count.
module beam_threshold_servo #(
  parameter int                      NBEAMS       = 2,
  parameter int                      THRESH_WIDTH = 18,
  parameter int                      COUNT_WIDTH  = 16,
  parameter int                      PERIOD_WIDTH = 24,
  parameter logic [THRESH_WIDTH-1:0] THRESH_INIT  = 18'd4096
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    enable_i,
  input  logic [PERIOD_WIDTH-1:0] period_i,
  input  logic [COUNT_WIDTH-1:0]  target_i,
  input  logic [THRESH_WIDTH-1:0] step_i,
  input  logic [THRESH_WIDTH-1:0] thresh_min_i,
  input  logic [THRESH_WIDTH-1:0] thresh_max_i,
`ifdef SERVO_HYST_EN
  input  logic [COUNT_WIDTH-1:0]  tol_i,
`endif
  input  logic [NBEAMS-1:0]       trigger_i,
  output logic [THRESH_WIDTH-1:0] thresh_o,
  output logic [NBEAMS-1:0]       thresh_ce_o,
  output logic                    update_o,
  output logic                    busy_o,
  output logic                    window_done_o
);

  localparam int IDX_W = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBEAMS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_UPDATE, S_COUNT, S_ADJUST} state_t;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [THRESH_WIDTH-1:0] r_thresh [NBEAMS];
  logic [COUNT_WIDTH-1:0]  r_cnt    [NBEAMS];
  logic [PERIOD_WIDTH-1:0] r_period;
  logic [PERIOD_WIDTH-1:0] r_timer;

  logic [IDX_W-1:0]        w_idx_inc;
  logic [THRESH_WIDTH-1:0] w_cur;
  logic [COUNT_WIDTH-1:0]  w_cnt;
  logic                    w_raise;
  logic                    w_lower;
  logic [THRESH_WIDTH:0]   w_sum;
  logic [THRESH_WIDTH:0]   w_dif;
  logic [THRESH_WIDTH:0]   w_next;
  logic [THRESH_WIDTH-1:0] w_adj;

  assign w_idx_inc = r_idx + 1'b1;
  assign w_cur     = r_thresh[r_idx];
  assign w_cnt     = r_cnt[r_idx];

`ifdef SERVO_HYST_EN
  assign w_raise = {1'b0, w_cnt} > ({1'b0, target_i} + {1'b0, tol_i});
  assign w_lower = ({1'b0, w_cnt} + {1'b0, tol_i}) < {1'b0, target_i};
`else
  assign w_raise = w_cnt > target_i;
  assign w_lower = w_cnt < target_i;
`endif

  // One extra bit: carry on the raise path, borrow flag on the lower path.
  assign w_sum = {1'b0, w_cur} + {1'b0, step_i};
  assign w_dif = {1'b0, w_cur} - {1'b0, step_i};

  always_comb begin
    w_next = {1'b0, w_cur};
    if (w_raise) begin
      w_next = w_sum;
    end else if (w_lower) begin
      if (w_dif[THRESH_WIDTH] || (w_dif < {1'b0, thresh_min_i})) begin
        w_next = {1'b0, thresh_min_i};
      end else begin
        w_next = w_dif;
      end
    end
    // Max clamp last so an inverted min/max pair resolves to max.
    if ((w_raise || w_lower) && (w_next > {1'b0, thresh_max_i})) begin
      w_next = {1'b0, thresh_max_i};
    end
  end

  assign w_adj = w_next[THRESH_WIDTH-1:0];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_period      <= '0;
      r_timer       <= '0;
      for (int b = 0; b < NBEAMS; b++) begin
        r_thresh[b] <= THRESH_INIT;
        r_cnt[b]    <= '0;
      end
      thresh_o      <= '0;
      thresh_ce_o   <= '0;
      update_o      <= 1'b0;
      busy_o        <= 1'b0;
      window_done_o <= 1'b0;
    end else begin
      thresh_ce_o   <= '0;
      update_o      <= 1'b0;
      window_done_o <= 1'b0;
      if (!enable_i) begin
        r_state <= S_IDLE;
        busy_o  <= 1'b0;
      end else begin
        busy_o <= 1'b1;
        case (r_state)
          S_IDLE: begin
            r_state     <= S_LOAD;
            r_idx       <= '0;
            thresh_o    <= r_thresh[0];
            thresh_ce_o <= NBEAMS'(1);
          end
          S_LOAD: begin
            if (r_idx == IDX_LAST) begin
              r_state  <= S_UPDATE;
              update_o <= 1'b1;
            end else begin
              r_idx       <= w_idx_inc;
              thresh_o    <= r_thresh[w_idx_inc];
              thresh_ce_o <= NBEAMS'(1) << w_idx_inc;
            end
          end
          S_UPDATE: begin
            r_state  <= S_COUNT;
            r_timer  <= PERIOD_WIDTH'(1);
            r_period <= (period_i == '0) ? PERIOD_WIDTH'(1) : period_i;
            for (int b = 0; b < NBEAMS; b++) begin
              r_cnt[b] <= '0;
            end
          end
          S_COUNT: begin
            for (int b = 0; b < NBEAMS; b++) begin
              if (trigger_i[b] && (r_cnt[b] != '1)) begin
                r_cnt[b] <= r_cnt[b] + 1'b1;
              end
            end
            if (r_timer >= r_period) begin
              r_state       <= S_ADJUST;
              r_idx         <= '0;
              window_done_o <= 1'b1;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          S_ADJUST: begin
            r_thresh[r_idx] <= w_adj;
            if (r_idx == IDX_LAST) begin
              // Beam 0 may be the one being written this cycle when NBEAMS is 1.
              r_state     <= S_LOAD;
              r_idx       <= '0;
              thresh_o    <= (r_idx == '0) ? w_adj : r_thresh[0];
              thresh_ce_o <= NBEAMS'(1);
            end else begin
              r_idx <= w_idx_inc;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_beam_threshold_servo.sv
// tb/tb_beam_threshold_servo.sv - self-checking bench for beam_threshold_servo against a window-level reference model
module tb_beam_threshold_servo;

  localparam int NB = 2;
  localparam int TW = 18;
  localparam int CW = 16;
  localparam int PW = 24;
  localparam int TMAX = (1 << TW) - 1;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          enable_i = 1'b0;
  logic [PW-1:0] period_i = '0;
  logic [CW-1:0] target_i = '0;
  logic [TW-1:0] step_i = '0;
  logic [TW-1:0] thresh_min_i = '0;
  logic [TW-1:0] thresh_max_i = '0;
`ifdef SERVO_HYST_EN
  logic [CW-1:0] tol_i = '0;
`endif
  logic [NB-1:0] trigger_i = '0;
  logic [TW-1:0] thresh_o;
  logic [NB-1:0] thresh_ce_o;
  logic          update_o;
  logic          busy_o;
  logic          window_done_o;

  int tests = 0;
  int failed = 0;
  int model [NB];
  int tol_v = 0;

  beam_threshold_servo dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .enable_i      (enable_i),
    .period_i      (period_i),
    .target_i      (target_i),
    .step_i        (step_i),
    .thresh_min_i  (thresh_min_i),
    .thresh_max_i  (thresh_max_i),
`ifdef SERVO_HYST_EN
    .tol_i         (tol_i),
`endif
    .trigger_i     (trigger_i),
    .thresh_o      (thresh_o),
    .thresh_ce_o   (thresh_ce_o),
    .update_o      (update_o),
    .busy_o        (busy_o),
    .window_done_o (window_done_o)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Threshold rule for one beam after a window, in plain integer arithmetic.
  function automatic int adj(int r, int c, int t, int s, int mn, int mx);
    int v;
    v = r;
    if (c > t + tol_v) begin
      v = r + s;
      if (v > mx) v = mx;
    end else if (c + tol_v < t) begin
      v = r - s;
      if (v < mn) v = mn;
      if (v > mx) v = mx;
    end
    return v;
  endfunction

  // Entered with LOAD beam 0 visible; leaves with the next LOAD beam 0 visible.
  // mode 0: beam b triggers high for the first hi[b] cycles; mode 1: random triggers.
  task automatic window(input int per, input int tgt, input int stp, input int mn, input int mx,
                        input int mode, input int n0, input int n1);
    int p;
    int cnt [NB];
    int hi [NB];
    logic [NB-1:0] t;
    hi[0] = n0;
    hi[1] = n1;
    period_i     = PW'(per);
    target_i     = CW'(tgt);
    step_i       = TW'(stp);
    thresh_min_i = TW'(mn);
    thresh_max_i = TW'(mx);
`ifdef SERVO_HYST_EN
    tol_i        = CW'(tol_v);
`endif
    for (int b = 0; b < NB; b++) begin
      check("load_thresh", 32'(thresh_o), 32'(model[b]));
      check("load_ce", 32'(thresh_ce_o), 32'(1 << b));
      check("load_update_low", 32'(update_o), 32'd0);
      trigger_i = NB'($urandom_range(0, 3));
      tick();
    end
    check("update_pulse", 32'(update_o), 32'd1);
    check("update_ce_low", 32'(thresh_ce_o), 32'd0);
    trigger_i = NB'($urandom_range(0, 3));
    tick();
    p = (per == 0) ? 1 : per;
    for (int b = 0; b < NB; b++) cnt[b] = 0;
    check("count_busy", 32'(busy_o), 32'd1);
    for (int c = 0; c < p; c++) begin
      for (int b = 0; b < NB; b++) begin
        t[b] = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'(c < hi[b]);
        if (t[b]) cnt[b]++;
      end
      trigger_i = t;
      if (c == p - 1) check("window_done_early", 32'(window_done_o), 32'd0);
      tick();
    end
    check("window_done", 32'(window_done_o), 32'd1);
    for (int b = 0; b < NB; b++) begin
      if (cnt[b] > 65535) cnt[b] = 65535;
      model[b] = adj(model[b], cnt[b], tgt, stp, mn, mx);
      trigger_i = NB'($urandom_range(0, 3));
      tick();
      check("adjust_ce_low", 32'(thresh_ce_o), (b == NB - 1) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    for (int b = 0; b < NB; b++) model[b] = 4096;
    tick();
    tick();
    check("rst_thresh", 32'(thresh_o), 32'd0);
    check("rst_ce", 32'(thresh_ce_o), 32'd0);
    check("rst_update", 32'(update_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_window_done", 32'(window_done_o), 32'd0);
    aresetn = 1'b1;
    tick();
    check("idle_busy", 32'(busy_o), 32'd0);
    check("idle_ce", 32'(thresh_ce_o), 32'd0);

    enable_i = 1'b1;
    tick();
    window(100, 10, 16, 0, TMAX, 0, 20, 0);
    window(20, 10, 16, 0, TMAX, 0, 0, 0);
    window(20, 10, 16, 0, 4100, 0, 20, 20);
    window(20, 10, 4092, 0, TMAX, 0, 0, 0);
    window(20, 10, 16, 0, TMAX, 0, 0, 20);
    window(20, 10, 16, 5000, 3000, 0, 0, 0);
    window(30, 10, 16, 0, TMAX, 0, 10, 10);
    window(0, 0, 7, 0, TMAX, 0, 1, 0);
    window(70000, 65534, 16, 0, TMAX, 0, 70000, 0);
    for (int i = 0; i < 8; i++) begin
      window($urandom_range(1, 40), $urandom_range(0, 20), $urandom_range(0, 600),
             $urandom_range(0, 3500), $urandom_range(2500, 6000), 1, 0, 0);
    end
`ifdef SERVO_HYST_EN
    tol_v = 5;
    window(30, 10, 16, 0, TMAX, 0, 14, 16);
    window(30, 10, 16, 0, TMAX, 0, 4, 0);
    window(30, 10, 16, 0, TMAX, 0, 15, 5);
`endif

    check("abort_load_ce0", 32'(thresh_ce_o), 32'd1);
    enable_i = 1'b0;
    tick();
    check("abort_ce", 32'(thresh_ce_o), 32'd0);
    check("abort_update", 32'(update_o), 32'd0);
    check("abort_busy", 32'(busy_o), 32'd0);
    tick();
    check("abort_ce_hold", 32'(thresh_ce_o), 32'd0);
    check("abort_update_hold", 32'(update_o), 32'd0);
    enable_i = 1'b1;
    tick();
    window(12, 5, 100, 0, TMAX, 1, 0, 0);
    window(12, 5, 100, 0, TMAX, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
